// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch initiator with PC, single-cycle SRAM requests and a small fetch buffer
module instr_fetch #(
    parameter logic [31:0] BOOT_PC = 32'h0000_0004,
    parameter int          DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_word_q [DEPTH];

    logic empty;
    logic pop;
    logic push;
    logic space;
    logic unused_target_bits;

    assign empty              = (count_q == '0);
    assign instr_valid_o      = ~empty & ~redirect_i;
    assign pop                = instr_valid_o & instr_ready_i;
    assign space              = (count_q < FULL_CNT) | pop;
    assign push               = enable_i & ~redirect_i & space & ~rst_i;
    assign unused_target_bits = ^redirect_pc_i[1:0];

    assign mem_req_o   = push;
    assign mem_we_o    = 1'b0;
    assign mem_wdata_o = 32'h0;
    assign mem_addr_o  = {2'b00, pc_q[31:2]};

    // Head is forced to zero when empty so reset and idle outputs are deterministic.
    assign instr_o    = empty ? 32'h0 : buf_word_q[rd_ptr_q];
    assign instr_pc_o = empty ? 32'h0 : buf_pc_q[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_i) begin
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= BOOT_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed through a nonzero count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= pc_q;
            buf_word_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_q <= FULL_CNT);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized scoreboard bench for instr_fetch against a queue-based fetch model
module tb_instr_fetch;

    localparam logic [31:0] BOOT_PC = 32'h0000_0004;
    localparam int          DEPTH   = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        instr_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    int   n_checks = 0;
    int   n_pass = 0;
    bit   sim_done = 1'b0;
    ent_t mq[$];
    ent_t exp_q[$];
    logic [31:0] m_pc = BOOT_PC;

    instr_fetch #(.BOOT_PC(BOOT_PC), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM image: word k holds 0x1000_0000 + k.
    assign mem_rdata_i = 32'h1000_0000 + mem_addr_o;

    function automatic logic [31:0] sram_word(input logic [31:0] byte_pc);
        return 32'h1000_0000 + (byte_pc >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the buffer is a plain queue of {pc, word}; deliveries go to the scoreboard.
    always @(negedge clk_i) begin
        bit m_valid, m_pop, m_req;
        if (!sim_done) begin
            m_valid = (mq.size() != 0) && !redirect_i;
            m_pop   = m_valid && instr_ready_i;
            m_req   = enable_i && !redirect_i && !rst_i && ((mq.size() < DEPTH) || m_pop);
            check("mem_req", mem_req_o, m_req);
            check("instr_valid", instr_valid_o, m_valid);
            check("mem_addr", mem_addr_o, m_pc >> 2);
            check("mem_we", mem_we_o, 0);
            check("mem_wdata", mem_wdata_o, 0);
            if (m_valid) begin
                check("head_pc", instr_pc_o, mq[0].pc);
                check("head_word", instr_o, mq[0].word);
            end
            if (rst_i) begin
                mq.delete();
                m_pc = BOOT_PC;
            end else if (redirect_i) begin
                mq.delete();
                m_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end else begin
                if (m_pop) exp_q.push_back(mq.pop_front());
                if (m_req) begin
                    mq.push_back('{pc: m_pc, word: sram_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: every DUT handshake must match the next delivery the model predicted.
    always @(negedge clk_i) begin
        ent_t e;
        #2;
        if (!sim_done && !rst_i && instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery_pc", instr_pc_o, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pc", instr_pc_o, e.pc);
                check("deliver_word", instr_o, e.word);
            end
        end
    end

    task automatic drive(input logic rst, input logic en, input logic rdy, input logic rd,
                         input logic [31:0] tgt, input int n);
        rst_i         = rst;
        enable_i      = en;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 32'h0, 2);
        check("rst_instr", instr_o, 32'h0);
        check("rst_instr_pc", instr_pc_o, 32'h0);
        check("rst_req", mem_req_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_addr", mem_addr_o, 32'h1);

        drive(0, 1, 1, 0, 32'h0, 10);
        drive(1, 0, 0, 0, 32'h0, 1);
        drive(0, 1, 0, 0, 32'h0, 5);
        drive(0, 1, 1, 0, 32'h0, 4);
        drive(0, 1, 0, 0, 32'h0, 3);
        drive(0, 1, 1, 0, 32'h0, 4);
        drive(0, 1, 0, 0, 32'h0, 3);
        drive(0, 1, 0, 1, 32'h0000_0041, 1);
        check("redir_next_addr", mem_addr_o, 32'd16);
        drive(0, 1, 1, 0, 32'h0, 6);
        drive(0, 1, 1, 1, 32'hFFFF_FFF8, 1);
        drive(0, 1, 1, 0, 32'h0, 6);
        drive(0, 1, 0, 0, 32'h0, 3);
        drive(1, 1, 0, 0, 32'h0, 1);
        check("midrst_valid", instr_valid_o, 0);
        check("midrst_req", mem_req_o, 0);
        drive(0, 1, 1, 0, 32'h0, 5);
        drive(0, 1, 1, 1, 32'h0000_0100, 1);
        drive(0, 1, 1, 1, 32'h0000_0203, 1);
        drive(0, 1, 1, 0, 32'h0, 4);
        drive(1, 1, 1, 1, 32'h0000_0500, 1);
        drive(0, 1, 1, 0, 32'h0, 3);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFF0 + $urandom_range(0, 15));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), tgt, 1);
        end

        drive(0, 0, 1, 0, 32'h0, 4);
        drive(0, 0, 0, 0, 32'h0, 2);
        check("drain_scoreboard", exp_q.size(), 0);
        sim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch initiator that drives the request side of the single-cycle instruction SRAM interface (req/we/addr/wdata/rdata).
- Holds the program counter and issues one word read per cycle.
- Buffers fetched words with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Sits between the instruction SRAM and the decode stage; the branch unit redirects it.

Parameters:
BOOT_PC, 32'h0000_0004, byte address of the first fetch after reset (word 1; word 0 is reserved).
DEPTH, 2, fetch-buffer entries (power of two, ≥2).

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
enable_i  input  1  fetch enable; 0 halts new requests, buffer still drains
mem_req_o  output  1  SRAM request
mem_we_o  output  1  SRAM write enable, constant 0
mem_addr_o  output  32  SRAM word index = {2'b00, pc_q[31:2]}
mem_wdata_o  output  32  constant 0
mem_rdata_i  input  32  SRAM read data, valid combinationally in the request cycle
instr_valid_o  output  1  head entry valid
instr_ready_i  input  1  decode accepts head
instr_o  output  32  head instruction word
instr_pc_o  output  32  head instruction byte PC
redirect_i  input  1  branch/jump redirect
redirect_pc_i  input  32  redirect target byte address

Behaviour:
- Single clock clk_i. Reset rst_i is synchronous, active-high, and takes priority over everything, including mid-fetch and a concurrent redirect.
- Reset state: pc_q=BOOT_PC, count=0, rd/wr pointers=0.
- Reset outputs: mem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, mem_addr_o=BOOT_PC>>2.
- Read timing: SRAM read is zero-latency. mem_rdata_i is sampled at the rising edge ending a cycle with mem_req_o=1; there are no outstanding requests across cycles.
- pop = instr_valid_o & instr_ready_i.
- space = (count<DEPTH) | pop.
- mem_req_o = enable_i & ~redirect_i & space & ~rst_i. This is combinational and may be asserted in back-to-back cycles.
- On a request edge: push {pc_q, mem_rdata_i} at wr_ptr; pc_q <= pc_q+4. The increment is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop, including full with pop.
- instr_valid_o = (count!=0) & ~redirect_i. instr_o and instr_pc_o show the head entry; they are don't-care when not valid but must be stable while valid & ~ready.
- Redirect (redirect_i=1), one cycle, priority over push and pop:
  - no request and no pop that cycle;
  - at the edge: count<=0, pointers<=0, pc_q <= {redirect_pc_i[31:2],2'b00} (bits [1:0] ignored);
  - the first fetch from the target can occur in the next cycle.
- Back-to-back redirects: the last one wins.
- enable_i=0: pc_q holds; buffered entries still pop normally.
- Full (count==DEPTH) without pop: mem_req_o=0, pc_q holds.
- Empty: instr_valid_o=0. No bypass: a word fetched in cycle N is first presented in cycle N+1, so fetch-to-decode latency is 1 cycle.
- Steady state (ready=1, enable=1): one instruction per cycle, no bubbles.
- FIFO pointers wrap modulo DEPTH.
- No overflow/underflow is reachable; an assertion checks count ≤ DEPTH.

Test Plan:
- Reset then enable=1, ready=1, SRAM model loaded with word k = 32'h1000_0000+k:
  - mem_addr_o sequence is 1,2,3,...;
  - instr_valid_o is first high one cycle after the first request, with instr_pc_o=4 and instr_o=32'h1000_0001;
  - then one instruction per cycle.
- ready=0 for 5 cycles from empty:
  - exactly 2 requests, for word indices 1 and 2, then mem_req_o=0;
  - the head holds pc 4 stably;
  - on ready=1: pc 4 then pc 8 are delivered; fetch resumes the same cycle as the first pop, at index 3.
- Full buffer, assert ready with enable=1: simultaneous pop and push each cycle, count stays 2, no skipped or duplicated PC.
- Redirect to 32'h0000_0041 while the buffer is full:
  - that cycle instr_valid_o=0 and mem_req_o=0;
  - next cycle mem_addr_o=16;
  - the next delivered instr_pc_o=32'h40, with no stale entries.
- Redirect to 32'hFFFF_FFF8 with streaming: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset asserted mid-stream with ready=0 and the buffer full:
  - next cycle instr_valid_o=0 and mem_req_o=0;
  - after release, fetch restarts at word 1 (pc 4).
